// File: rtl/prv664_define.sv
// rtl/prv664_define.sv - shared flush-cause and flush FSM state types
// Purpose : types shared by pip_flush_ctrl and pip_flush_arb.
// Contents: flush_cause_e  - why the pipeline is being redirected
//           flush_state_e  - pip_flush_ctrl sequencing state
package prv664_define;

    typedef enum logic [2:0] {
        FC_NONE,
        FC_BOOT,
        FC_TRAP,
        FC_MISPRED,
        FC_FENCEI
    } flush_cause_e;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_IDLE,
        ST_CFLUSH
    } flush_state_e;

endpackage

// File: rtl/pip_flush_interface.sv
// rtl/pip_flush_interface.sv - pipeline redirect bundle from commit to all stages and BPU
// Purpose : carries the redirect pc and the flush/hold/flushbpu controls.
// Signals : newpc    - redirect target, valid while flush=1
//           flush    - one-cycle pipeline flush
//           hold     - freeze all stages
//           flushbpu - also clear speculative BPU state
// Modports: master (pip_flush_ctrl), slave (pipeline stages, BPU)
interface pip_flush_interface #(
    parameter int unsigned XLEN = 64
);
    logic [XLEN-1:0] newpc;
    logic            flush;
    logic            hold;
    logic            flushbpu;

    modport master (output newpc, output flush, output hold, output flushbpu);
    modport slave  (input  newpc, input  flush, input  hold, input  flushbpu);
endinterface

// File: rtl/pip_flush_arb.sv
// rtl/pip_flush_arb.sv - combinational priority select of redirect source
// Purpose : picks one redirect among trap > fencei > mispred; lower-priority
//           requests in the same cycle are dropped.
// Ports   : trap_valid/trap_pc, fencei_valid/fencei_pc, mispred_valid/mispred_pc
//           cause    - winning cause (FC_NONE when nothing requested)
//           pc       - winning redirect pc ('0 when none)
//           flushbpu - winning cause also clears the BPU
module pip_flush_arb
    import prv664_define::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mispred_valid,
    input  logic [XLEN-1:0] mispred_pc,
    input  logic            fencei_valid,
    input  logic [XLEN-1:0] fencei_pc,
    output flush_cause_e    cause,
    output logic [XLEN-1:0] pc,
    output logic            flushbpu
);

    always_comb begin
        cause    = FC_NONE;
        pc       = '0;
        flushbpu = 1'b0;
        if (trap_valid) begin
            cause    = FC_TRAP;
            pc       = trap_pc;
            flushbpu = 1'b1;
        end else if (fencei_valid) begin
            cause    = FC_FENCEI;
            pc       = fencei_pc;
            flushbpu = 1'b1;
        end else if (mispred_valid) begin
            // A mispredict only corrects one path; predictor state stays valid.
            cause    = FC_MISPRED;
            pc       = mispred_pc;
            flushbpu = 1'b0;
        end
    end

endmodule

// File: rtl/pip_flush_ctrl.sv
// rtl/pip_flush_ctrl.sv - pipeline redirect controller beside the commit stage
// Purpose : arbitrates trap / fence.i / mispredict redirects, issues the boot
//           redirect after reset and stalls the pipeline during the fence.i
//           cache writeback+invalidate.
// Ports   : clk_i, srst_i (sync, active-high)
//           trap_valid_i/trap_pc_i, mispred_valid_i/mispred_pc_i,
//           fencei_valid_i/fencei_pc_i, hold_req_i
//           cache_flush_req_o (level) / cache_flush_ack_i (1-cycle pulse)
//           wdt_err_o - fence.i ack watchdog pulse
//           flush_m   - pip_flush_interface.master (newpc/flush/hold/flushbpu)
// Options : PIP_FLUSH_WDT_EN - enables the WDT_CYCLES ack watchdog; without it
//           wdt_err_o is tied 0 and the cache flush waits indefinitely.
module pip_flush_ctrl
    import prv664_define::*;
#(
    parameter int unsigned     XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int unsigned     WDT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              trap_valid_i,
    input  logic [XLEN-1:0]   trap_pc_i,
    input  logic              mispred_valid_i,
    input  logic [XLEN-1:0]   mispred_pc_i,
    input  logic              fencei_valid_i,
    input  logic [XLEN-1:0]   fencei_pc_i,
    input  logic              hold_req_i,
    output logic              cache_flush_req_o,
    input  logic              cache_flush_ack_i,
    output logic              wdt_err_o,
    pip_flush_interface.master flush_m
);

    flush_state_e    state_q;
    logic            flush_q;
    logic            flushbpu_q;
    logic            hold_q;
    logic [XLEN-1:0] newpc_q;
    logic            creq_q;
    logic            pend_valid_q;
    logic [XLEN-1:0] pend_pc_q;

    flush_cause_e    arb_cause;
    logic [XLEN-1:0] arb_pc;
    logic            arb_bpu;
    logic            cflush_done;

    pip_flush_arb #(
        .XLEN (XLEN)
    ) u_arb (
        .trap_valid    (trap_valid_i),
        .trap_pc       (trap_pc_i),
        .mispred_valid (mispred_valid_i),
        .mispred_pc    (mispred_pc_i),
        .fencei_valid  (fencei_valid_i),
        .fencei_pc     (fencei_pc_i),
        .cause         (arb_cause),
        .pc            (arb_pc),
        .flushbpu      (arb_bpu)
    );

`ifdef PIP_FLUSH_WDT_EN
    localparam int unsigned WDT_W = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;

    logic [WDT_W-1:0] wdt_cnt_q;
    logic             wdt_err_q;
    logic             wdt_expire;

    // Counter sits at zero outside CFLUSH, so the first CFLUSH cycle sees 0.
    assign wdt_expire = (state_q == ST_CFLUSH) && !cache_flush_ack_i &&
                        (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wdt_cnt_q <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            wdt_err_q <= wdt_expire;
            if (state_q == ST_CFLUSH && !cflush_done) begin
                wdt_cnt_q <= wdt_cnt_q + 1'b1;
            end else begin
                wdt_cnt_q <= '0;
            end
        end
    end

    assign cflush_done = cache_flush_ack_i | wdt_expire;
    assign wdt_err_o   = wdt_err_q;
`else
    assign cflush_done = cache_flush_ack_i;
    assign wdt_err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q      <= ST_BOOT;
            flush_q      <= 1'b0;
            flushbpu_q   <= 1'b0;
            hold_q       <= 1'b0;
            newpc_q      <= '0;
            creq_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            // flush/flushbpu are single-cycle pulses; newpc holds its value.
            flush_q    <= 1'b0;
            flushbpu_q <= 1'b0;
            unique case (state_q)
                ST_BOOT: begin
                    flush_q    <= 1'b1;
                    flushbpu_q <= 1'b1;
                    newpc_q    <= RESET_PC;
                    hold_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                ST_IDLE: begin
                    hold_q <= hold_req_i;
                    if (arb_cause != FC_NONE) begin
                        flush_q    <= 1'b1;
                        flushbpu_q <= arb_bpu;
                        newpc_q    <= arb_pc;
                    end
                    if (arb_cause == FC_FENCEI) begin
                        // Raise hold together with the request so the stall
                        // covers every cycle the caches are busy.
                        creq_q  <= 1'b1;
                        hold_q  <= 1'b1;
                        state_q <= ST_CFLUSH;
                    end
                end
                ST_CFLUSH: begin
                    if (trap_valid_i) begin
                        pend_valid_q <= 1'b1;
                        pend_pc_q    <= trap_pc_i;
                    end
                    if (cflush_done) begin
                        creq_q       <= 1'b0;
                        hold_q       <= hold_req_i;
                        state_q      <= ST_IDLE;
                        pend_valid_q <= 1'b0;
                        // A trap arriving on the ack cycle is the newest one.
                        if (trap_valid_i || pend_valid_q) begin
                            flush_q    <= 1'b1;
                            flushbpu_q <= 1'b1;
                            newpc_q    <= trap_valid_i ? trap_pc_i : pend_pc_q;
                        end
                    end
                end
                default: state_q <= ST_BOOT;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        assert (WDT_CYCLES > 1)
            else $error("pip_flush_ctrl: WDT_CYCLES must be at least 2");
        if (!srst_i && state_q == ST_CFLUSH) begin
            assert (!(mispred_valid_i || fencei_valid_i))
                else $error("pip_flush_ctrl: mispred/fencei while cache flush in progress");
        end
    end
`endif

    assign cache_flush_req_o = creq_q;
    assign flush_m.newpc     = newpc_q;
    assign flush_m.flush     = flush_q;
    assign flush_m.hold      = hold_q;
    assign flush_m.flushbpu  = flushbpu_q;

endmodule

// File: tb/tb_pip_flush_ctrl.sv
// tb/tb_pip_flush_ctrl.sv - self-checking bench for pip_flush_ctrl
module tb_pip_flush_ctrl;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_pc = '0;
    logic        mispred_valid = 1'b0;
    logic [63:0] mispred_pc = '0;
    logic        fencei_valid = 1'b0;
    logic [63:0] fencei_pc = '0;
    logic        hold_req = 1'b0;
    logic        cache_flush_req;
    logic        cache_flush_ack = 1'b0;
    logic        wdt_err;

    always #5 clk = ~clk;

    pip_flush_interface #(.XLEN(64)) fi ();

    pip_flush_ctrl #(
        .XLEN       (64),
        .RESET_PC   (RST_PC),
        .WDT_CYCLES (16)
    ) dut (
        .clk_i             (clk),
        .srst_i            (srst),
        .trap_valid_i      (trap_valid),
        .trap_pc_i         (trap_pc),
        .mispred_valid_i   (mispred_valid),
        .mispred_pc_i      (mispred_pc),
        .fencei_valid_i    (fencei_valid),
        .fencei_pc_i       (fencei_pc),
        .hold_req_i        (hold_req),
        .cache_flush_req_o (cache_flush_req),
        .cache_flush_ack_i (cache_flush_ack),
        .wdt_err_o         (wdt_err),
        .flush_m           (fi)
    );

    typedef struct {
        logic        rst;
        logic        tv;
        logic [63:0] tpc;
        logic        mv;
        logic [63:0] mpc;
        logic        fv;
        logic [63:0] fpc;
        logic        hr;
        logic        ack;
        logic        ef;
        logic        eb;
        logic        eh;
        logic        ec;
        logic        ew;
        logic [63:0] epc;
    } vec_t;

    vec_t table_q[$];
    vec_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   row      = 0;

    function automatic vec_t mk(
        input longint unsigned rst, input longint unsigned tv, input longint unsigned tpc,
        input longint unsigned mv, input longint unsigned mpc,
        input longint unsigned fv, input longint unsigned fpc,
        input longint unsigned hr, input longint unsigned ack,
        input longint unsigned ef, input longint unsigned eb, input longint unsigned eh,
        input longint unsigned ec, input longint unsigned ew, input longint unsigned epc);
        vec_t v;
        v.rst = rst[0]; v.tv = tv[0]; v.tpc = tpc;
        v.mv  = mv[0];  v.mpc = mpc;
        v.fv  = fv[0];  v.fpc = fpc;
        v.hr  = hr[0];  v.ack = ack[0];
        v.ef  = ef[0];  v.eb = eb[0]; v.eh = eh[0]; v.ec = ec[0]; v.ew = ew[0];
        v.epc = epc;
        return v;
    endfunction

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b expected %b", nm, row, act, exp);
        end
    endtask

    task automatic check_pc(input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL newpc row %0d: got %h expected %h", row, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outcome, compare after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        srst            = v.rst;
        trap_valid      = v.tv;
        trap_pc         = v.tpc;
        mispred_valid   = v.mv;
        mispred_pc      = v.mpc;
        fencei_valid    = v.fv;
        fencei_pc       = v.fpc;
        hold_req        = v.hr;
        cache_flush_ack = v.ack;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_bit("flush", fi.flush, e.ef);
        check_bit("flushbpu", fi.flushbpu, e.eb);
        check_bit("hold", fi.hold, e.eh);
        check_bit("cache_flush_req", cache_flush_req, e.ec);
        check_bit("wdt_err", wdt_err, e.ew);
        check_pc(fi.newpc, e.epc);
        row++;
    endtask

    initial begin
        // rst tv tpc mv mpc fv fpc hr ack | flush bpu hold creq wdt newpc
        table_q.push_back(mk(1,0,0,0,0,0,0,0,0,            0,0,0,0,0,0));
        table_q.push_back(mk(1,1,'h10,1,'h20,1,'h30,1,1,   0,0,0,0,0,0));
        table_q.push_back(mk(0,1,'h999,0,0,0,0,1,0,        1,1,0,0,0,RST_PC));
        table_q.push_back(mk(0,0,0,0,0,0,0,0,0,            0,0,0,0,0,RST_PC));
        table_q.push_back(mk(0,1,'h100,1,'h200,0,0,0,0,    1,1,0,0,0,'h100));
        table_q.push_back(mk(0,0,0,0,0,0,0,0,0,            0,0,0,0,0,'h100));
        table_q.push_back(mk(0,0,0,1,'h8000_1000,0,0,0,0,  1,0,0,0,0,'h8000_1000));
        table_q.push_back(mk(0,0,0,0,0,0,0,1,0,            0,0,1,0,0,'h8000_1000));
        table_q.push_back(mk(0,0,0,1,'h40,0,0,1,0,         1,0,1,0,0,'h40));
        table_q.push_back(mk(0,1,'h50,0,0,0,0,0,0,         1,1,0,0,0,'h50));
        table_q.push_back(mk(0,0,0,1,'h2000,1,'h1000,0,0,  1,1,1,1,0,'h1000));
        table_q.push_back(mk(0,0,0,0,0,0,0,0,0,            0,0,1,1,0,'h1000));
        table_q.push_back(mk(0,0,0,0,0,0,0,1,1,            0,0,1,0,0,'h1000));
        table_q.push_back(mk(0,0,0,0,0,0,0,0,0,            0,0,0,0,0,'h1000));
        table_q.push_back(mk(0,1,'h60,0,0,1,'h70,0,0,      1,1,0,0,0,'h60));
        table_q.push_back(mk(0,0,0,0,0,0,0,0,0,            0,0,0,0,0,'h60));

        for (int i = 0; i < table_q.size(); i++) begin
            step(table_q[i]);
        end

        // fence.i with ack 10 cycles later and a trap parked in cycle 4
        step(mk(0,0,0,0,0,1,'h8000_0044,0,0,               1,1,1,1,0,'h8000_0044));
        for (int k = 1; k <= 9; k++) begin
            step(mk(0,(k == 4),'h300,0,0,0,0,0,0,          0,0,1,1,0,'h8000_0044));
        end
        step(mk(0,0,0,0,0,0,0,0,1,                         1,1,0,0,0,'h300));
        step(mk(0,0,0,0,0,0,0,0,0,                         0,0,0,0,0,'h300));

        // later trap overwrites the pending one; hold_req on the ack edge
        step(mk(0,0,0,0,0,1,'hA00,0,0,                     1,1,1,1,0,'hA00));
        step(mk(0,1,'hB00,0,0,0,0,0,0,                     0,0,1,1,0,'hA00));
        step(mk(0,1,'hC00,0,0,0,0,0,0,                     0,0,1,1,0,'hA00));
        step(mk(0,0,0,0,0,0,0,1,1,                         1,1,1,0,0,'hC00));
        step(mk(0,0,0,0,0,0,0,0,0,                         0,0,0,0,0,'hC00));

        // reset in the third CFLUSH cycle discards the pending trap
        step(mk(0,0,0,0,0,1,'hD00,0,0,                     1,1,1,1,0,'hD00));
        step(mk(0,1,'hE00,0,0,0,0,0,0,                     0,0,1,1,0,'hD00));
        step(mk(0,0,0,0,0,0,0,0,0,                         0,0,1,1,0,'hD00));
        step(mk(1,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0));
        step(mk(0,0,0,0,0,0,0,0,0,                         1,1,0,0,0,RST_PC));
        step(mk(0,0,0,0,0,0,0,0,1,                         0,0,0,0,0,RST_PC));

`ifdef PIP_FLUSH_WDT_EN
        // no ack: watchdog fires after 16 CFLUSH cycles and honours the trap
        step(mk(0,0,0,0,0,1,'hF00,0,0,                     1,1,1,1,0,'hF00));
        for (int k = 1; k <= 15; k++) begin
            step(mk(0,(k == 5),'hF40,0,0,0,0,0,0,          0,0,1,1,0,'hF00));
        end
        step(mk(0,0,0,0,0,0,0,0,0,                         1,1,0,0,1,'hF40));
        step(mk(0,0,0,0,0,0,0,0,0,                         0,0,0,0,0,'hF40));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
